dmem_bank: RTL and testbench
============================

Name: dmem_bank

Overview:
- Parametrised single-clock data memory for the MIPS-E FPGA datapath; next generation of the fixed data memory.
- Adds per-byte write enables, an optional registered read, and a post-reset clear sweep.
- Adds a valid/ready loader port so graph/edge tables are streamed in at run time rather than baked in as initial contents.
- Out-of-range accesses are handled explicitly and flagged.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 16, word-address width.
- DEPTH, 1024, number of words; DEPTH <= 2**ADDR_W.
- RD_REG, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = contents untouched by reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  ADDR_W  CPU word address.
- rd  out  DATA_W  CPU read data.
- wd  in  DATA_W  CPU write data.
- we  in  1  CPU write enable.
- be  in  DATA_W/8  CPU byte enables; bit i gates wd[8i+7:8i].
- ld_valid  in  1  loader word offered.
- ld_ready  out  1  loader word accepted this cycle when ld_valid is also high.
- ld_addr  in  ADDR_W  loader word address.
- ld_data  in  DATA_W  loader word; always a full-word write.
- busy  out  1  clear sweep in progress.
- err  out  1  sticky out-of-range flag.

Behaviour:
- FSM states: CLEAR, RUN.
  - rst=1: state <= CLEAR if CLEAR_ON_RESET, else RUN; clear counter <= 0; err <= 0; registered rd <= 0.
- CLEAR state:
  - Each cycle writes 0 to mem[cnt], then cnt <= cnt+1.
  - The write at cnt == DEPTH-1 moves the FSM to RUN.
  - busy is high for exactly DEPTH cycles after rst falls; it is 1 while rst is high if CLEAR_ON_RESET, else 0.
- While busy:
  - CPU writes are dropped.
  - rd returns 0.
  - ld_ready = 0.
- Reset asserted mid-sweep restarts the sweep from address 0.
- RUN state, CPU write:
  - Condition: we=1 and a < DEPTH.
  - For each i with be[i]=1, byte i of mem[a] <= wd byte i; other bytes are unchanged.
  - be=0 with we=1 is a no-op.
- RUN state, loader:
  - ld_ready = ~we (CPU has priority).
  - Transfer occurs on ld_valid & ld_ready.
  - On transfer, mem[ld_addr] <= ld_data if ld_addr < DEPTH.
  - ld_ready is combinational; ld_valid must not depend on ld_ready.
- Reads, RD_REG=0:
  - rd = mem[a] combinationally.
  - A write to the same address becomes visible on the cycle after the edge (write-then-read ordering, as in the existing datapath).
- Reads, RD_REG=1:
  - rd <= mem[a] at each edge (read-old-data).
  - A same-cycle write to a is returned on the following read, not the current one.
- Out of range:
  - CPU read with a >= DEPTH returns 0.
  - CPU write or loader transfer with address >= DEPTH is dropped.
  - Any of these in RUN sets err <= 1; err is cleared only by rst.
- Simultaneous CPU write and ld_valid: CPU writes; loader waits with ld_ready=0, so no loss.
- Address compare uses full ADDR_W. The index into the storage array uses clog2(DEPTH) bits, only after the range check.

Decomposition:
- Shared package/header (extend def.h):
  - DATA_W and DEPTH defaults.
  - State encoding constants: ST_CLEAR=1'b0, ST_RUN=1'b1.
  - Byte-lane count DATA_W/8.
- One sub-module: dmem_bank_ram.
  - Pure storage array, single write port with byte-enable vector and one read port.
  - Optional output register selected by RD_REG.
  - Lets the FPGA tool infer block RAM when RD_REG=1.
- FSM, clear counter, arbitration and range checks live in dmem_bank.

Test Plan:
- Bench parameters: DEPTH=8, DATA_W=32, CLEAR_ON_RESET=1.
- Clear sweep: rst for 2 cycles then release -> busy high exactly 8 cycles, then 0. Reading a=0..7 returns 32'h0. A CPU write during busy is dropped (read back 0).
- Loader stream: push 32'h080d0001, 32'h00020102 to addrs 0,1 with ld_valid held -> ld_ready=1, one word per cycle. rd at a=0 = 32'h080d0001, a=1 = 32'h00020102.
- Byte enables: mem[2]=32'h01030104, then we=1, be=4'b0101, wd=32'hAABBCCDD -> mem[2]=32'h01BB01DD.
- Contention: we=1 at a=3 and ld_valid=1 to addr 4 in the same cycle -> ld_ready=0. CPU write lands; loader word lands the next cycle once we=0. Both read back correctly.
- Range and reset: write to a=9 -> memory unchanged, err=1 and stays 1. Read a=9 -> 0. rst mid-sweep at cycle 4 -> sweep restarts, busy 8 more cycles, err cleared.
- RD_REG=1 rerun: read of a=1 appears one cycle later. Same-cycle write then read of a=1 returns old data, then new data on the next cycle.

Source files
------------

// File: rtl/dmem_bank_pkg.sv
// Shared constants for the banked data memory: defaults, FSM encoding, lane helpers.
package dmem_bank_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 1024;

   localparam logic ST_CLEAR = 1'b0;
   localparam logic ST_RUN   = 1'b1;

   function automatic int lanes(input int data_w);
      return data_w / 8;
   endfunction

   // Storage index width; a one-word memory still needs a 1-bit index.
   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dmem_bank_ram.sv
// Byte-lane storage array: one byte-masked write port, one read port, optional output register.
module dmem_bank_ram
   import dmem_bank_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int IDX_W  = 10,
   parameter int RD_REG = 0
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [IDX_W-1:0]      raddr,
   output logic [DATA_W-1:0]     rdata
);

   // One narrow array per lane keeps each write port a plain full-width write.
   for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clk) begin
         if (we && be[gi]) begin
            mem[waddr] <= wdata[gi*8 +: 8];
         end
      end

      if (RD_REG != 0) begin : g_rreg
         logic [7:0] q_reg;
         always_ff @(posedge clk) begin
            q_reg <= mem[raddr];
         end
         assign rdata[gi*8 +: 8] = q_reg;
      end else begin : g_rcomb
         assign rdata[gi*8 +: 8] = mem[raddr];
      end
   end

endmodule

// File: rtl/dmem_bank.sv
// Data memory with byte enables, run-time loader port, post-reset clear sweep and
// a sticky out-of-range flag.
module dmem_bank
   import dmem_bank_pkg::*;
#(
   parameter int DATA_W         = DATA_W_DEF,
   parameter int ADDR_W         = 16,
   parameter int DEPTH          = DEPTH_DEF,
   parameter int RD_REG         = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_W-1:0]           a,
   output logic [DATA_W-1:0]           rd,
   input  logic [DATA_W-1:0]           wd,
   input  logic                        we,
   input  logic [lanes(DATA_W)-1:0]    be,
   input  logic                        ld_valid,
   output logic                        ld_ready,
   input  logic [ADDR_W-1:0]           ld_addr,
   input  logic [DATA_W-1:0]           ld_data,
   output logic                        busy,
   output logic                        err
);

   localparam int LANES = lanes(DATA_W);
   localparam int IDX_W = idx_w(DEPTH);
   localparam logic [ADDR_W:0]  DEPTH_L     = (ADDR_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DEPTH - 1);
   localparam logic             RST_STATE   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
   localparam logic             BUSY_IN_RST = (CLEAR_ON_RESET != 0);

   logic             state_reg, state_next;
   logic [IDX_W-1:0] cnt_reg, cnt_next;
   logic             err_reg, err_next;
   logic             zero_reg;

   logic clearing, run, a_in, ld_in, cpu_wr, ld_xfer, ld_wr, rd_zero;

   logic              ram_we;
   logic [LANES-1:0]  ram_be;
   logic [IDX_W-1:0]  ram_waddr, ram_raddr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   assign clearing = ~rst & (state_reg == ST_CLEAR);
   assign run      = ~rst & (state_reg == ST_RUN);
   assign busy     = rst ? BUSY_IN_RST : (state_reg == ST_CLEAR);

   // Range checks use the full address; storage is only indexed once in range.
   assign a_in      = {1'b0, a} < DEPTH_L;
   assign ld_in     = {1'b0, ld_addr} < DEPTH_L;
   assign ram_raddr = a_in ? a[IDX_W-1:0] : '0;

   assign ld_ready = run & ~we;
   assign ld_xfer  = ld_valid & ld_ready;
   assign cpu_wr   = run & we & a_in;
   assign ld_wr    = ld_xfer & ld_in;

   always_comb begin
      ram_we    = 1'b0;
      ram_be    = '0;
      ram_waddr = '0;
      ram_wdata = '0;
      if (clearing) begin
         ram_we    = 1'b1;
         ram_be    = '1;
         ram_waddr = cnt_reg;
      end else if (cpu_wr) begin
         ram_we    = 1'b1;
         ram_be    = be;
         ram_waddr = a[IDX_W-1:0];
         ram_wdata = wd;
      end else if (ld_wr) begin
         ram_we    = 1'b1;
         ram_be    = '1;
         ram_waddr = ld_addr[IDX_W-1:0];
         ram_wdata = ld_data;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      err_next   = err_reg;
      if (clearing) begin
         cnt_next = cnt_reg + 1'b1;
         if (cnt_reg == LAST_IDX) begin
            state_next = ST_RUN;
            cnt_next   = '0;
         end
      end
      if (run && (!a_in || (ld_xfer && !ld_in))) begin
         err_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RST_STATE;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
         zero_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
         zero_reg  <= busy | ~a_in;
      end
   end

   // With a registered read the zeroing decision is delayed alongside the data.
   assign rd_zero = (RD_REG != 0) ? zero_reg : (busy | ~a_in);
   assign rd      = rd_zero ? '0 : ram_rdata;
   assign err     = err_reg;

   dmem_bank_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W),
      .RD_REG (RD_REG)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .be    (ram_be),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_dmem_bank.sv
// Bench for dmem_bank: directed vector table, corner sequences and random traffic,
// with one combinational-read and one registered-read instance on shared inputs.
module tb_dmem_bank;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int DEP = 8;

   logic          clk;
   logic          rst;
   logic [AW-1:0] a;
   logic [DW-1:0] wd;
   logic          we;
   logic [3:0]    be;
   logic          lv;
   logic [AW-1:0] la;
   logic [DW-1:0] ldd;

   logic [DW-1:0] rd0, rd1;
   logic          rdy0, rdy1, busy0, busy1, err0, err1;

   dmem_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_REG(0), .CLEAR_ON_RESET(1)) dut0 (
      .clk(clk), .rst(rst), .a(a), .rd(rd0), .wd(wd), .we(we), .be(be),
      .ld_valid(lv), .ld_ready(rdy0), .ld_addr(la), .ld_data(ldd),
      .busy(busy0), .err(err0)
   );

   dmem_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_REG(1), .CLEAR_ON_RESET(1)) dut1 (
      .clk(clk), .rst(rst), .a(a), .rd(rd1), .wd(wd), .we(we), .be(be),
      .ld_valid(lv), .ld_ready(rdy1), .ld_addr(la), .ld_data(ldd),
      .busy(busy1), .err(err1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: whole-memory view, cycles left in the sweep, sticky error.
   logic [31:0] m_mem [DEP];
   int          m_left;
   logic        m_err;
   logic [31:0] m_rd1;

   logic [31:0] s_rd0, s_rd1;
   logic        s_rdy, s_busy, s_err;

   typedef struct {
      logic        rst;
      logic [15:0] a;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wd;
      logic        lv;
      logic [15:0] la;
      logic [31:0] ldd;
      logic [31:0] e_rd;
      logic        e_rdy;
      logic        e_busy;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic [15:0] aa, input logic w, input logic [3:0] b,
                      input logic [31:0] d, input logic v, input logic [15:0] lad,
                      input logic [31:0] ldv, input logic [31:0] erd, input logic erdy,
                      input logic ebusy, input logic eerr);
      vec_t x;
      x.rst = r; x.a = aa; x.we = w; x.be = b; x.wd = d;
      x.lv = v; x.la = lad; x.ldd = ldv;
      x.e_rd = erd; x.e_rdy = erdy; x.e_busy = ebusy; x.e_err = eerr;
      tbl.push_back(x);
   endtask

   task automatic idle_in(input logic r, input logic [15:0] aa);
      rst = r; a = aa; we = 1'b0; be = 4'h0; wd = '0; lv = 1'b0; la = '0; ldd = '0;
   endtask

   // Called just after a falling edge with inputs set; checks, then advances one clock.
   task automatic cycle();
      logic        e_busy, e_run, e_rdy;
      logic [31:0] e_rd0, nrd1;
      #1;
      s_rd0 = rd0; s_rd1 = rd1; s_rdy = rdy0; s_busy = busy0; s_err = err0;
      e_busy = rst || (m_left > 0);
      e_run  = !rst && (m_left == 0);
      e_rdy  = e_run && !we;
      e_rd0  = (e_busy || a >= DEP) ? 32'h0 : m_mem[a[2:0]];
      chk("busy", {31'b0, busy0}, {31'b0, e_busy});
      chk("busy_rreg", {31'b0, busy1}, {31'b0, e_busy});
      chk("ld_ready", {31'b0, rdy0}, {31'b0, e_rdy});
      chk("ld_ready_rreg", {31'b0, rdy1}, {31'b0, e_rdy});
      chk("err", {31'b0, err0}, {31'b0, m_err});
      chk("err_rreg", {31'b0, err1}, {31'b0, m_err});
      chk("rd_comb", rd0, e_rd0);
      chk("rd_reg", rd1, m_rd1);
      nrd1 = rst ? 32'h0 : e_rd0;
      if (rst) begin
         m_left = DEP;
         m_err  = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            for (int k = 0; k < DEP; k++) m_mem[k] = 32'h0;
         end
      end else begin
         if (a >= DEP) m_err = 1'b1;
         if (we && a < DEP) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) m_mem[a[2:0]][8*i +: 8] = wd[8*i +: 8];
            end
         end
         if (lv && e_rdy) begin
            if (la < DEP) m_mem[la[2:0]] = ldd;
            else m_err = 1'b1;
         end
      end
      m_rd1 = nrd1;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int cnt;

      idle_in(1'b1, 16'h0);
      @(posedge clk);
      @(negedge clk);
      m_left = DEP;
      m_err  = 1'b0;
      m_rd1  = 32'h0;

      // Directed table: expectations are the outputs seen before the row's clock edge.
      add(1, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 1, 0);
      for (int i = 0; i < DEP; i++) begin
         if (i == 0) add(0, 5, 1, 4'hF, 32'hDEADBEEF, 0, 0, 0, 32'h0, 0, 1, 0);
         else        add(0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 1, 0);
      end
      for (int i = 0; i < DEP; i++) add(0, 16'(i), 0, 4'h0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
      add(0, 0, 0, 4'h0, 0, 1, 0, 32'h080d0001, 32'h0, 1, 0, 0);
      add(0, 0, 0, 4'h0, 0, 1, 1, 32'h00020102, 32'h080d0001, 1, 0, 0);
      add(0, 1, 0, 4'h0, 0, 0, 0, 0, 32'h00020102, 1, 0, 0);
      add(0, 1, 0, 4'h0, 0, 1, 2, 32'h01030104, 32'h00020102, 1, 0, 0);
      add(0, 2, 1, 4'b0101, 32'hAABBCCDD, 0, 0, 0, 32'h01030104, 0, 0, 0);
      add(0, 2, 0, 4'h0, 0, 0, 0, 0, 32'h01BB01DD, 1, 0, 0);
      add(0, 3, 1, 4'hF, 32'h11223344, 1, 4, 32'h55667788, 32'h0, 0, 0, 0);
      add(0, 3, 0, 4'h0, 0, 1, 4, 32'h55667788, 32'h11223344, 1, 0, 0);
      add(0, 4, 0, 4'h0, 0, 0, 0, 0, 32'h55667788, 1, 0, 0);
      add(0, 9, 1, 4'hF, 32'hFFFFFFFF, 0, 0, 0, 32'h0, 0, 0, 0);
      add(0, 9, 0, 4'h0, 0, 0, 0, 0, 32'h0, 1, 0, 1);
      add(0, 1, 0, 4'h0, 0, 0, 0, 0, 32'h00020102, 1, 0, 1);
      add(0, 2, 0, 4'h0, 0, 0, 0, 0, 32'h01BB01DD, 1, 0, 1);
      add(1, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 1, 1);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 1, 0);
      add(1, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 1, 0);
      for (int i = 0; i < DEP; i++) add(0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 1, 0);
      add(0, 4, 0, 4'h0, 0, 0, 0, 0, 32'h0, 1, 0, 0);

      foreach (tbl[r]) begin
         rst = tbl[r].rst; a = tbl[r].a; we = tbl[r].we; be = tbl[r].be; wd = tbl[r].wd;
         lv = tbl[r].lv; la = tbl[r].la; ldd = tbl[r].ldd;
         cycle();
         chk("tbl_rd", s_rd0, tbl[r].e_rd);
         chk("tbl_ld_ready", {31'b0, s_rdy}, {31'b0, tbl[r].e_rdy});
         chk("tbl_busy", {31'b0, s_busy}, {31'b0, tbl[r].e_busy});
         chk("tbl_err", {31'b0, s_err}, {31'b0, tbl[r].e_err});
      end

      // Sweep length after a two-cycle reset, bounded in case busy never drops.
      idle_in(1'b1, 16'h0);
      cycle();
      cycle();
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (!s_busy) break;
         cnt++;
      end
      chk("busy_len", 32'(cnt), 32'd8);

      // Registered read: same-cycle write returns old data, new data one read later.
      idle_in(1'b0, 16'd1);
      we = 1'b1; be = 4'hF; wd = 32'hCAFEF00D;
      cycle();
      we = 1'b0;
      cycle();
      chk("rdreg_old_data", s_rd1, 32'h0);
      chk("rdcomb_new_data", s_rd0, 32'hCAFEF00D);
      cycle();
      chk("rdreg_new_data", s_rd1, 32'hCAFEF00D);

      for (int k = 0; k < 400; k++) begin
         rst = ($urandom_range(63, 0) == 0);
         a   = ($urandom_range(9, 0) == 0) ? 16'($urandom_range(12, 8)) : 16'($urandom_range(7, 0));
         we  = ($urandom_range(2, 0) == 0);
         be  = 4'($urandom_range(15, 0));
         wd  = $urandom();
         lv  = 1'($urandom_range(1, 0));
         la  = 16'($urandom_range(8, 0));
         ldd = $urandom();
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
